// File: rtl/db_strobe_cmp.sv
// Receive-side strobe comparator for one tester pin.
// A double-buffered expected value and mask are checked against a synchronised
// pin sample taken at a programmable clock within each test cycle. The block
// keeps a sticky fail flag, a saturating fail count and the index of the first
// failing test cycle.
module db_strobe_cmp #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en_cmp_logic,
    input  logic             i_load_exp,
    input  logic             i_transfer_exp,
    input  logic             i_exp,
    input  logic             i_load_mask,
    input  logic             i_transfer_mask,
    input  logic             i_mask,
    input  logic             i_dut_in,
    input  logic [6:0]       i_strobe_edge_1,
    input  logic [6:0]       i_strobe_edge_2,
    input  logic [7:0]       i_cycle_length_1,
    input  logic             i_test_cycle,
    input  logic             i_clr_status,
    output logic             o_sample,
    output logic             o_fail_pulse,
    output logic             o_fail,
    output logic             o_cycle_done,
    output logic [CNT_W-1:0] o_fail_count,
    output logic [CNT_W-1:0] o_first_fail_cycle
);

    localparam int unsigned LEN_W  = 8;
    localparam int unsigned EDGE_W = 7;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_exp_buf;
    logic                   r_exp_act;
    logic                   r_mask_buf;
    logic                   r_mask_act;
    logic [LEN_W-1:0]       r_cnt;
    logic                   r_cycle_done;
    logic [CNT_W-1:0]       r_cidx;

    logic                   r_s1_vld;
    logic                   r_sample;
    logic                   r_exp_s;
    logic                   r_mask_s;
    logic [CNT_W-1:0]       r_cidx_s;

    logic                   r_fail_pulse;
    logic                   r_fail;
    logic [CNT_W-1:0]       r_fail_count;
    logic [CNT_W-1:0]       r_first_fail;

    logic                   w_din_s;
    logic [LEN_W-1:0]       w_len_m1;
    logic [LEN_W-1:0]       w_strobe_edge;
    logic                   w_last;
    logic                   w_strobe;
    logic                   w_mismatch;

    // Cycle-boundary, strobe-point and compare-result decode
    always_comb begin
        w_din_s       = r_sync[SYNC_STAGES-1];
        w_len_m1      = i_cycle_length_1 - LEN_W'(1);
        w_strobe_edge = {1'b0, (i_test_cycle ? i_strobe_edge_2 : i_strobe_edge_1)};
        w_last        = i_en_cmp_logic && (i_cycle_length_1 != '0) && (r_cnt == w_len_m1);
        // An edge at or beyond the cycle length never strobes; this also covers length 0
        w_strobe      = i_en_cmp_logic && (r_cnt == w_strobe_edge)
                        && (w_strobe_edge < i_cycle_length_1);
        w_mismatch    = r_s1_vld && r_mask_s && (r_sample ^ r_exp_s);
    end

    // Pin synchroniser: pin-to-din_s latency equals SYNC_STAGES clocks
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= i_dut_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Expected-value and mask double buffers; transfer always takes the pre-load buffer
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_exp_buf  <= 1'b0;
            r_exp_act  <= 1'b0;
            r_mask_buf <= 1'b0;
            r_mask_act <= 1'b0;
        end else begin
            if (i_load_exp)      r_exp_buf  <= i_exp;
            if (i_transfer_exp)  r_exp_act  <= r_exp_buf;
            if (i_load_mask)     r_mask_buf <= i_mask;
            if (i_transfer_mask) r_mask_act <= r_mask_buf;
        end
    end

    // Clock-within-test-cycle counter and registered end-of-cycle pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt        <= '0;
            r_cycle_done <= 1'b0;
        end else begin
            r_cycle_done <= w_last;
            if (!i_en_cmp_logic || (i_cycle_length_1 == '0) || w_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + LEN_W'(1);
            end
        end
    end

    // Test-cycle index advances together with CYCLE_DONE; status clear takes priority
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cidx <= '0;
        end else if (i_clr_status) begin
            r_cidx <= '0;
        end else if (w_last) begin
            r_cidx <= r_cidx + CNT_W'(1);
        end
    end

    // Stage 1: capture the pin sample with the expectation active before this clock
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_vld <= 1'b0;
            r_sample <= 1'b0;
            r_exp_s  <= 1'b0;
            r_mask_s <= 1'b0;
            r_cidx_s <= '0;
        end else begin
            r_s1_vld <= w_strobe;
            if (w_strobe) begin
                r_sample <= w_din_s;
                r_exp_s  <= r_exp_act;
                r_mask_s <= r_mask_act;
                r_cidx_s <= r_cidx;
            end
        end
    end

    // Stage 2: resolve the compare and update the accumulated status
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fail_pulse <= 1'b0;
            r_fail       <= 1'b0;
            r_fail_count <= '0;
            r_first_fail <= '0;
        end else begin
            r_fail_pulse <= w_mismatch;
            if (i_clr_status) begin
                r_fail       <= 1'b0;
                r_fail_count <= '0;
                r_first_fail <= '0;
            end else if (w_mismatch) begin
                r_fail <= 1'b1;
                if (r_fail_count != '1) begin
                    r_fail_count <= r_fail_count + CNT_W'(1);
                end
                if (r_fail_count == '0) begin
                    r_first_fail <= r_cidx_s;
                end
            end
        end
    end

    // Output mapping
    always_comb begin
        o_sample           = r_sample;
        o_fail_pulse       = r_fail_pulse;
        o_fail             = r_fail;
        o_cycle_done       = r_cycle_done;
        o_fail_count       = r_fail_count;
        o_first_fail_cycle = r_first_fail;
    end

endmodule

// File: tb/tb_db_strobe_cmp.sv
// Scoreboard bench for db_strobe_cmp: expected CYCLE_DONE / FAIL_PULSE events
// (with the bench clock index at which they must appear) are queued by the
// stimulus and consumed by an independent monitor.
module tb_db_strobe_cmp;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_cmp_logic;
    logic        load_exp, transfer_exp, exp_v;
    logic        load_mask, transfer_mask, mask_v;
    logic        dut_in;
    logic [6:0]  strobe_edge_1, strobe_edge_2;
    logic [7:0]  cycle_length_1;
    logic        test_cycle;
    logic        clr_status;

    logic        sample0, fail_pulse0, fail0, cycle_done0;
    logic [15:0] fail_count0, first_fail0;
    logic        sample1, fail_pulse1, fail1, cycle_done1;
    logic [3:0]  fail_count1, first_fail1;

    int checks   = 0;
    int failures = 0;
    int tb_cyc   = 0;

    typedef struct {
        int cyc;
        bit cd;
        bit fp;
    } ev_t;

    ev_t exp_q[$];

    db_strobe_cmp #(.SYNC_STAGES(2), .CNT_W(16)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_en_cmp_logic(en_cmp_logic),
        .i_load_exp(load_exp), .i_transfer_exp(transfer_exp), .i_exp(exp_v),
        .i_load_mask(load_mask), .i_transfer_mask(transfer_mask), .i_mask(mask_v),
        .i_dut_in(dut_in), .i_strobe_edge_1(strobe_edge_1), .i_strobe_edge_2(strobe_edge_2),
        .i_cycle_length_1(cycle_length_1), .i_test_cycle(test_cycle), .i_clr_status(clr_status),
        .o_sample(sample0), .o_fail_pulse(fail_pulse0), .o_fail(fail0),
        .o_cycle_done(cycle_done0), .o_fail_count(fail_count0), .o_first_fail_cycle(first_fail0)
    );

    db_strobe_cmp #(.SYNC_STAGES(2), .CNT_W(4)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_en_cmp_logic(en_cmp_logic),
        .i_load_exp(load_exp), .i_transfer_exp(transfer_exp), .i_exp(exp_v),
        .i_load_mask(load_mask), .i_transfer_mask(transfer_mask), .i_mask(mask_v),
        .i_dut_in(dut_in), .i_strobe_edge_1(strobe_edge_1), .i_strobe_edge_2(strobe_edge_2),
        .i_cycle_length_1(cycle_length_1), .i_test_cycle(test_cycle), .i_clr_status(clr_status),
        .o_sample(sample1), .o_fail_pulse(fail_pulse1), .o_fail(fail1),
        .o_cycle_done(cycle_done1), .o_fail_count(fail_count1), .o_first_fail_cycle(first_fail1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    // Monitor: every CYCLE_DONE / FAIL_PULSE must match the oldest expected event
    always @(negedge clk) begin
        if (cycle_done0 || fail_pulse0) begin
            ev_t e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL event_unexpected at cyc=%0d: got cd=%0b fp=%0b, required no event",
                         tb_cyc, cycle_done0, fail_pulse0);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != tb_cyc || e.cd != cycle_done0 || e.fp != fail_pulse0) begin
                    failures++;
                    $display("FAIL event_match: got cyc=%0d cd=%0b fp=%0b, required cyc=%0d cd=%0b fp=%0b",
                             tb_cyc, cycle_done0, fail_pulse0, e.cyc, e.cd, e.fp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Insert an expected event in time order, merging events on the same clock
    task automatic exp_event(input int cyc, input bit cd, input bit fp);
        ev_t e;
        int  pos;
        bit  found;
        pos   = exp_q.size();
        found = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (!found && exp_q[i].cyc == cyc) begin
                exp_q[i].cd = exp_q[i].cd | cd;
                exp_q[i].fp = exp_q[i].fp | fp;
                found = 1'b1;
            end else if (!found && exp_q[i].cyc > cyc && pos == exp_q.size()) begin
                pos = i;
            end
        end
        if (!found) begin
            e.cyc = cyc;
            e.cd  = cd;
            e.fp  = fp;
            exp_q.insert(pos, e);
        end
    endtask

    task automatic set_exp(input logic v);
        exp_v = v; load_exp = 1'b1; step();
        load_exp = 1'b0; transfer_exp = 1'b1; step();
        transfer_exp = 1'b0;
    endtask

    task automatic set_mask(input logic v);
        mask_v = v; load_mask = 1'b1; step();
        load_mask = 1'b0; transfer_mask = 1'b1; step();
        transfer_mask = 1'b0;
    endtask

    task automatic do_clear();
        clr_status = 1'b1; step();
        clr_status = 1'b0;
    endtask

    task automatic settle();
        step(); step();
    endtask

    // Enable for n clocks; pin is inverted from base for clock offsets glo..ghi
    task automatic run_en(input int n, input logic base, input int glo, input int ghi);
        for (int i = 0; i < n; i++) begin
            dut_in       = (i >= glo && i <= ghi) ? ~base : base;
            en_cmp_logic = 1'b1;
            step();
        end
        en_cmp_logic = 1'b0;
        dut_in       = base;
    endtask

    task automatic drain(input string name);
        repeat (5) step();
        chk(name, exp_q.size(), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sample"},      int'(sample0), 0);
        chk({tag, "_fail_pulse"},  int'(fail_pulse0), 0);
        chk({tag, "_fail"},        int'(fail0), 0);
        chk({tag, "_cycle_done"},  int'(cycle_done0), 0);
        chk({tag, "_fail_count"},  int'(fail_count0), 0);
        chk({tag, "_first_fail"},  int'(first_fail0), 0);
        chk({tag, "_fail_count4"}, int'(fail_count1), 0);
        chk({tag, "_fail4"},       int'(fail1), 0);
    endtask

    initial begin
        int c0;
        rst = 1'b1; en_cmp_logic = 1'b0;
        load_exp = 1'b0; transfer_exp = 1'b0; exp_v = 1'b0;
        load_mask = 1'b0; transfer_mask = 1'b0; mask_v = 1'b0;
        dut_in = 1'b0; strobe_edge_1 = 7'd4; strobe_edge_2 = 7'd7;
        cycle_length_1 = 8'd10; test_cycle = 1'b0; clr_status = 1'b0;

        // Reset state
        repeat (3) step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();

        // Matching pin for 5 cycles: CYCLE_DONE every 10 clocks, no fails
        set_exp(1'b1); set_mask(1'b1);
        dut_in = 1'b1; settle(); do_clear();
        c0 = tb_cyc;
        for (int n = 0; n < 5; n++) exp_event(c0 + (n + 1) * 10, 1'b1, 1'b0);
        run_en(50, 1'b1, -1, -1);
        drain("t1_queue");
        chk("t1_fail", int'(fail0), 0);
        chk("t1_fail_count", int'(fail_count0), 0);
        chk("t1_sample", int'(sample0), 1);

        // Pin low during cycle 2 only: one fail two clocks after that strobe
        do_clear();
        c0 = tb_cyc;
        for (int n = 0; n < 5; n++) exp_event(c0 + (n + 1) * 10, 1'b1, 1'b0);
        exp_event(c0 + 2 * 10 + 4 + 2, 1'b0, 1'b1);
        run_en(50, 1'b1, 20, 29);
        drain("t2_queue");
        chk("t2_fail", int'(fail0), 1);
        chk("t2_fail_count", int'(fail_count0), 1);
        chk("t2_first_fail", int'(first_fail0), 2);
        chk("t2_sample", int'(sample0), 1);

        // Masked-off mismatches for 3 cycles, then mask enabled for one cycle
        dut_in = 1'b0;
        set_mask(1'b0); do_clear(); settle();
        c0 = tb_cyc;
        for (int n = 0; n < 3; n++) exp_event(c0 + (n + 1) * 10, 1'b1, 1'b0);
        run_en(30, 1'b0, -1, -1);
        drain("t3a_queue");
        chk("t3a_fail", int'(fail0), 0);
        chk("t3a_fail_count", int'(fail_count0), 0);
        set_mask(1'b1);
        c0 = tb_cyc;
        exp_event(c0 + 10, 1'b1, 1'b0);
        exp_event(c0 + 6, 1'b0, 1'b1);
        run_en(10, 1'b0, -1, -1);
        drain("t3b_queue");
        chk("t3b_fail_count", int'(fail_count0), 1);
        chk("t3b_first_fail", int'(first_fail0), 3);
        chk("t3b_sample", int'(sample0), 0);

        // TEST_CYCLE alternates edges 2 and 7; pin glitch seen only at count 7
        strobe_edge_1 = 7'd2; strobe_edge_2 = 7'd7;
        dut_in = 1'b1; settle(); do_clear();
        c0 = tb_cyc;
        for (int n = 0; n < 4; n++) begin
            exp_event(c0 + (n + 1) * 10, 1'b1, 1'b0);
            if (n % 2 == 1) exp_event(c0 + n * 10 + 9, 1'b0, 1'b1);
        end
        for (int i = 0; i < 40; i++) begin
            en_cmp_logic = 1'b1;
            test_cycle   = ((i / 10) % 2) == 1;
            dut_in       = (i % 10 == 5) ? 1'b0 : 1'b1;
            step();
        end
        en_cmp_logic = 1'b0; dut_in = 1'b1;
        drain("t4_queue");
        chk("t4_fail_count", int'(fail_count0), 2);
        chk("t4_first_fail", int'(first_fail0), 1);

        // Strobe edge beyond cycle length: no strobes
        strobe_edge_2 = 7'd12; test_cycle = 1'b1;
        dut_in = 1'b0; settle();
        c0 = tb_cyc;
        for (int n = 0; n < 2; n++) exp_event(c0 + (n + 1) * 10, 1'b1, 1'b0);
        run_en(20, 1'b0, -1, -1);
        drain("t4b_queue");
        chk("t4b_fail_count", int'(fail_count0), 2);

        // Cycle length 0: no strobes and no CYCLE_DONE
        cycle_length_1 = 8'd0; test_cycle = 1'b0;
        run_en(15, 1'b0, -1, -1);
        drain("t4c_queue");
        chk("t4c_fail_count", int'(fail_count0), 2);

        // TRANSFER_EXP in the strobe clock compares against the old active value
        cycle_length_1 = 8'd10; strobe_edge_1 = 7'd4; test_cycle = 1'b0;
        set_exp(1'b1);
        exp_v = 1'b0; load_exp = 1'b1; step(); load_exp = 1'b0;
        dut_in = 1'b1; settle(); do_clear();
        c0 = tb_cyc;
        exp_event(c0 + 10, 1'b1, 1'b0);
        exp_event(c0 + 20, 1'b1, 1'b0);
        exp_event(c0 + 16, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            en_cmp_logic = 1'b1;
            transfer_exp = (i == 4);
            step();
        end
        en_cmp_logic = 1'b0; transfer_exp = 1'b0;
        drain("t5a_queue");
        chk("t5a_fail_count", int'(fail_count0), 1);
        chk("t5a_first_fail", int'(first_fail0), 1);

        // LOAD and TRANSFER together: active takes old buffer (0), so pin 1 fails
        exp_v = 1'b1; load_exp = 1'b1; transfer_exp = 1'b1; step();
        load_exp = 1'b0; transfer_exp = 1'b0;
        do_clear();
        c0 = tb_cyc;
        exp_event(c0 + 10, 1'b1, 1'b0);
        exp_event(c0 + 6, 1'b0, 1'b1);
        run_en(10, 1'b1, -1, -1);
        drain("t5b_queue");
        chk("t5b_fail_count", int'(fail_count0), 1);
        chk("t5b_first_fail", int'(first_fail0), 0);
        transfer_exp = 1'b1; step(); transfer_exp = 1'b0;
        do_clear();
        c0 = tb_cyc;
        exp_event(c0 + 10, 1'b1, 1'b0);
        run_en(10, 1'b1, -1, -1);
        drain("t5c_queue");
        chk("t5c_fail_count", int'(fail_count0), 0);

        // Fail every clock (length 1, edge 0): 4-bit counter saturates, clear beats a fail
        cycle_length_1 = 8'd1; strobe_edge_1 = 7'd0;
        dut_in = 1'b0; settle(); do_clear();
        c0 = tb_cyc;
        for (int i = 0; i < 21; i++) begin
            exp_event(c0 + 1 + i, 1'b1, 1'b0);
            exp_event(c0 + 2 + i, 1'b0, 1'b1);
        end
        for (int i = 0; i < 21; i++) begin
            en_cmp_logic = 1'b1;
            step();
        end
        chk("t6_fail_count16", int'(fail_count0), 20);
        chk("t6_fail_count4_sat", int'(fail_count1), 15);
        chk("t6_fail4", int'(fail1), 1);
        chk("t6_first_fail", int'(first_fail0), 0);
        en_cmp_logic = 1'b0; clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        chk("t6_clr_fail_pulse", int'(fail_pulse0), 1);
        chk("t6_clr_fail", int'(fail0), 0);
        chk("t6_clr_fail_count", int'(fail_count0), 0);
        chk("t6_clr_fail_count4", int'(fail_count1), 0);
        chk("t6_clr_first_fail", int'(first_fail0), 0);
        drain("t6_queue");

        // Reset mid-cycle with a strobe in flight: everything clears, no pulse
        cycle_length_1 = 8'd10; strobe_edge_1 = 7'd4;
        dut_in = 1'b0; settle(); do_clear();
        c0 = tb_cyc;
        exp_event(c0 + 10, 1'b1, 1'b0);
        exp_event(c0 + 6, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) begin
            en_cmp_logic = 1'b1;
            step();
        end
        chk("t7_pre_fail", int'(fail0), 1);
        chk("t7_pre_fail_count", int'(fail_count0), 1);
        rst = 1'b1; en_cmp_logic = 1'b0;
        step();
        chk_all_zero("t7_rst");
        rst = 1'b0;
        drain("t7_queue");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/db_strobe_cmp.md
Name: db_strobe_cmp

Overview:
- Receive-side counterpart of the double-buffered pin driver in the ASIC tester.
- Samples one DUT output pin at a programmable strobe point inside each test cycle.
- Compares the sample against a double-buffered expected value, gated by a double-buffered compare-enable (mask).
- Accumulates pass/fail status, a saturating fail count and the index of the first failing test cycle, for readback by the tester controller.

Parameters:
- SYNC_STAGES, 2: number of synchroniser flops on DUT_IN; legal range 1..3.
- CNT_W, 16: width of FAIL_COUNT, FIRST_FAIL_CYCLE and the test-cycle index counter.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- EN_CMP_LOGIC  in  1  enables the cycle counter and strobing; low clears the cycle counter to 0.
- LOAD_EXP  in  1  loads EXP into the expected-value buffer.
- TRANSFER_EXP  in  1  activates the buffered expected value.
- EXP  in  1  expected pin value.
- LOAD_MASK  in  1  loads MASK into the mask buffer.
- TRANSFER_MASK  in  1  activates the buffered mask.
- MASK  in  1  1 = compare this cycle, 0 = don't care.
- DUT_IN  in  1  asynchronous DUT pin.
- STROBE_EDGE_1  in  7  strobe clock count used when TEST_CYCLE=0.
- STROBE_EDGE_2  in  7  strobe clock count used when TEST_CYCLE=1.
- CYCLE_LENGTH_1  in  8  clocks per test cycle.
- TEST_CYCLE  in  1  selects the strobe edge.
- CLR_STATUS  in  1  clears FAIL, FAIL_COUNT, FIRST_FAIL_CYCLE and the cycle index.
- SAMPLE  out  1  last strobed pin value.
- FAIL_PULSE  out  1  one-clock pulse on a masked mismatch.
- FAIL  out  1  sticky fail flag.
- CYCLE_DONE  out  1  one-clock pulse on the last clock of each test cycle.
- FAIL_COUNT  out  CNT_W  saturating count of failing strobes.
- FIRST_FAIL_CYCLE  out  CNT_W  test-cycle index of the first fail since clear.

Behaviour:
- Reset: all outputs, buffers, active registers, synchroniser flops and counters go to 0. Reset while counting aborts the current cycle; no pulse is issued.
- Synchroniser: DUT_IN passes through SYNC_STAGES flops to give din_s. Pin-to-din_s latency is SYNC_STAGES clocks.
- Double buffers:
  - exp_buf and mask_buf load on LOAD_*; exp_act and mask_act load from the buffers on TRANSFER_*.
  - LOAD and TRANSFER in the same clock transfers the OLD buffer value.
  - Independent priority-free regs.
- Cycle counter cnt (8 bit):
  - When EN_CMP_LOGIC=1: cnt <= (cnt == CYCLE_LENGTH_1-1) ? 0 : cnt+1.
  - When EN_CMP_LOGIC=0: cnt <= 0.
  - CYCLE_LENGTH_1 = 0: cnt holds 0, no strobes, no CYCLE_DONE.
  - CYCLE_LENGTH_1 = 1: cnt stays 0 and every clock is both a strobe candidate and CYCLE_DONE.
- Cycle index: cidx (CNT_W bits) increments, wrapping, on every CYCLE_DONE. CYCLE_DONE is registered and asserts the clock after cnt == CYCLE_LENGTH_1-1 with EN high.
- Strobe:
  - strobe_edge = TEST_CYCLE ? STROBE_EDGE_2 : STROBE_EDGE_1, zero-extended to 8 bits.
  - A strobe occurs when EN_CMP_LOGIC=1 and cnt == strobe_edge.
  - strobe_edge >= CYCLE_LENGTH_1: no strobe that cycle; not an error.
- Compare pipeline:
  - Stage 1, on the strobe clock: SAMPLE <= din_s; capture exp_act, mask_act and cidx into stage regs. Values are those present before any TRANSFER in that same clock.
  - Stage 2, next clock: mismatch = mask_s & (sample_s ^ exp_s). FAIL_PULSE <= mismatch.
  - On mismatch:
    - FAIL <= 1.
    - FAIL_COUNT increments, saturating at all-ones.
    - If FAIL_COUNT was 0, FIRST_FAIL_CYCLE <= captured cidx.
  - Strobe-to-FAIL_PULSE latency is 2 clocks from the strobe clock.
- CLR_STATUS:
  - Clears FAIL, FAIL_COUNT, FIRST_FAIL_CYCLE and cidx next clock.
  - Does not touch buffers, cnt or the pipeline.
  - If a mismatch resolves in the same clock, FAIL_PULSE still asserts but the clear wins for FAIL, FAIL_COUNT and FIRST_FAIL_CYCLE.
- EN_CMP_LOGIC dropped mid-pipeline: an already-captured stage-1 strobe still completes its stage-2 compare.

Test Plan:
- CYCLE_LENGTH_1=10, STROBE_EDGE_1=4, MASK=1, EXP=1, DUT_IN held 1, 5 cycles -> FAIL_PULSE never asserts, FAIL=0, CYCLE_DONE pulses every 10 clocks, cidx=5.
- Same setup, DUT_IN=0 during cycle 2 only -> exactly one FAIL_PULSE 2 clocks after the cycle-2 strobe, FAIL=1, FAIL_COUNT=1, FIRST_FAIL_CYCLE=2.
- MASK=0 transferred, DUT_IN mismatching for 3 cycles -> no FAIL_PULSE, FAIL_COUNT=0. Then transfer MASK=1 -> fail on the next strobe only.
- TEST_CYCLE toggling between STROBE_EDGE_1=2 and STROBE_EDGE_2=7 with a DUT_IN glitch only at count 7 -> fail only on TEST_CYCLE=1 cycles. STROBE_EDGE_2=12 with CYCLE_LENGTH_1=10 -> no strobes.
- TRANSFER_EXP in the strobe clock (old 1, new 0), DUT_IN=1 -> no fail. LOAD_EXP and TRANSFER_EXP together -> exp_act takes the old buffer value.
- CNT_W=4: force 20 fails -> FAIL_COUNT saturates at 15. CLR_STATUS coincident with a fail -> FAIL_PULSE=1, counters 0. RST mid-cycle -> all outputs 0 next clock.
